// File: rtl/dac_spi_tx_if.sv
// Host-side handshake and SPI pin bundle for the multi-channel DAC serializer.
interface dac_spi_tx_if #(
  parameter int DW  = 16,
  parameter int NCH = 2
);
  logic [NCH*DW-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic [1:0]        power_state;
  logic              speed_sel;
  logic              dac_sclk;
  logic              dac_mosi;
  logic              dac_csb;
  logic              busy;
  logic              frame_done;

  modport master (
    output sample_in, sample_valid, power_state, speed_sel,
    input  sample_ready, dac_sclk, dac_mosi, dac_csb, busy, frame_done
  );

  modport slave (
    input  sample_in, sample_valid, power_state, speed_sel,
    output sample_ready, dac_sclk, dac_mosi, dac_csb, busy, frame_done
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Multi-channel DAC serializer: one {power, channel, sample} SPI frame per channel,
// or a single broadcast frame when a power-down code is latched.
module dac_spi_tx #(
  parameter int DW        = 16,
  parameter int NCH       = 2,
  parameter int CHW       = 1,
  parameter int HALF_FAST = 1,
  parameter int HALF_SLOW = 4,
  parameter int GAP       = 2
) (
  input  logic           clk,
  input  logic           rst,
  dac_spi_tx_if.slave    bus
);
  localparam int FW   = 2 + CHW + DW;
  localparam int MAXA = (HALF_FAST > HALF_SLOW) ? HALF_FAST : HALF_SLOW;
  localparam int MAXC = (MAXA > GAP) ? MAXA : GAP;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam int BW   = $clog2(FW + 1);
  localparam logic [CHW-1:0] LASTCH = CHW'(NCH - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT_HI, ST_SHIFT_LO, ST_HOLD, ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       hm1_q, hm1_d;
  logic [BW-1:0]       bits_q, bits_d;
  logic [FW-1:0]       sh_q, sh_d;
  logic [NCH*DW-1:0]   samp_q, samp_d;
  logic [1:0]          ps_q, ps_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic                last_q, last_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                csb_q, csb_d;
  logic                done_q, done_d;
  logic                rdy_q, rdy_d;

  logic                cnt_zero;
  logic [FW-1:0]       frame_w;

  assign cnt_zero = (cnt_q == '0);
  // Power-down frames broadcast with zero address and data.
  assign frame_w  = (ps_q != 2'b00) ? {ps_q, {CHW{1'b0}}, {DW{1'b0}}}
                                    : {ps_q, ch_q, samp_q[ch_q*DW +: DW]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    hm1_d   = hm1_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    samp_d  = samp_q;
    ps_d    = ps_q;
    ch_d    = ch_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csb_d   = csb_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sample_valid && rdy_q) begin
          samp_d  = bus.sample_in;
          ps_d    = bus.power_state;
          hm1_d   = bus.speed_sel ? CW'(HALF_FAST - 1) : CW'(HALF_SLOW - 1);
          ch_d    = '0;
          last_d  = 1'b0;
          cnt_d   = '0;
          // One csb-high cycle before the first frame reuses the gap path.
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SETUP;
            csb_d   = 1'b0;
            cnt_d   = hm1_q;
            sh_d    = frame_w;
            bits_d  = BW'(FW);
          end
        end
      end
      ST_SETUP, ST_SHIFT_LO: begin
        if (cnt_zero) begin
          cnt_d = hm1_q;
          if (state_q == ST_SHIFT_LO && bits_q == '0) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_SHIFT_HI;
            sclk_d  = 1'b1;
            mosi_d  = sh_q[FW-1];
            sh_d    = {sh_q[FW-2:0], 1'b0};
            bits_d  = bits_q - 1'b1;
          end
        end
      end
      ST_SHIFT_HI: begin
        if (cnt_zero) begin
          state_d = ST_SHIFT_LO;
          sclk_d  = 1'b0;
          cnt_d   = hm1_q;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_GAP;
          csb_d   = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = CW'(GAP - 1);
          if (ps_q != 2'b00 || ch_q == LASTCH) last_d = 1'b1;
          else                                 ch_d   = ch_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hm1_q   <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      samp_q  <= '0;
      ps_q    <= '0;
      ch_q    <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csb_q   <= 1'b1;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hm1_q   <= hm1_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      samp_q  <= samp_d;
      ps_q    <= ps_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csb_q   <= csb_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.sample_ready = rdy_q;
  assign bus.dac_sclk     = sclk_q;
  assign bus.dac_mosi     = mosi_q;
  assign bus.dac_csb      = csb_q;
  assign bus.frame_done   = done_q;
  assign bus.busy         = (state_q != ST_IDLE);
endmodule
